// File: rtl/regfile_dump_reader.sv
// Walks an inclusive range of register-file indices and streams (index, value) pairs
// over a valid/ready port, keeping a wrap-around sum of every accepted value.
module regfile_dump_reader #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] first_reg,
   input  logic [ADDR_W-1:0] last_reg,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_index,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] checksum
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_HOLD = 2'd2,
      ST_FIN  = 2'd3
   } state_t;

   state_t            r_state, w_state_next;
   logic [ADDR_W-1:0] r_cur, w_cur_next;
   logic [ADDR_W-1:0] r_end, w_end_next;
   logic [ADDR_W-1:0] r_out_index, w_out_index_next;
   logic [DATA_W-1:0] r_out_data, w_out_data_next;
   logic [DATA_W-1:0] r_checksum, w_checksum_next;
   logic              r_out_valid, w_out_valid_next;
   logic              r_err, w_err_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cur       <= '0;
         r_end       <= '0;
         r_out_index <= '0;
         r_out_data  <= '0;
         r_checksum  <= '0;
         r_out_valid <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_cur       <= w_cur_next;
         r_end       <= w_end_next;
         r_out_index <= w_out_index_next;
         r_out_data  <= w_out_data_next;
         r_checksum  <= w_checksum_next;
         r_out_valid <= w_out_valid_next;
         r_err       <= w_err_next;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_cur_next       = r_cur;
      w_end_next       = r_end;
      w_out_index_next = r_out_index;
      w_out_data_next  = r_out_data;
      w_checksum_next  = r_checksum;
      w_out_valid_next = r_out_valid;
      w_err_next       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               if (first_reg <= last_reg) begin
                  w_cur_next      = first_reg;
                  w_end_next      = last_reg;
                  w_checksum_next = '0;
                  w_state_next    = ST_READ;
               end else begin
                  w_err_next = 1'b1;
               end
            end
         end
         ST_READ: begin
            w_out_data_next  = rd_data;
            w_out_index_next = r_cur;
            w_out_valid_next = 1'b1;
            w_state_next     = ST_HOLD;
         end
         ST_HOLD: begin
            if (out_ready) begin
               w_checksum_next  = r_checksum + r_out_data;
               w_out_valid_next = 1'b0;
               // Stop on the last index rather than incrementing, so the top index never wraps.
               if (r_cur == r_end) begin
                  w_state_next = ST_FIN;
               end else begin
                  w_cur_next   = r_cur + 1'b1;
                  w_state_next = ST_READ;
               end
            end
         end
         ST_FIN: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   assign rd_addr   = r_cur;
   assign out_valid = r_out_valid;
   assign out_index = r_out_index;
   assign out_data  = r_out_data;
   assign checksum  = r_checksum;
   assign err       = r_err;
   assign busy      = (r_state != ST_IDLE);
   assign done      = (r_state == ST_FIN);

endmodule
